// File: rtl/fpr_wb_arbiter_if.sv
// rtl/fpr_wb_arbiter_if.sv - bus bundle for the FP register file writeback arbiter
interface fpr_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // Requester 0: FPU result
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  // Requester 1: FP load data
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  // Decode issue into the pending-write scoreboard
  logic              iss_valid;
  logic              iss_ready;
  logic [ADDR_W-1:0] iss_rd;
  // Source operand hazard lookup
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              rs_busy;
  logic              rt_busy;
  // Register file write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  // Sticky protocol error
  logic              err;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  rs_addr, rt_addr,
    output rs_busy, rt_busy,
    output wr_en, wr_addr, wr_data,
    output err
  );

  // Requester / decode / register file side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output rs_addr, rt_addr,
    input  rs_busy, rt_busy,
    input  wr_en, wr_addr, wr_data,
    input  err
  );
endinterface

// File: rtl/fpr_wb_arbiter.sv
// rtl/fpr_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
module fpr_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  fpr_wb_arbiter_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Arbitration history: reset to 1 so requester 0 wins the first contest
  logic              r_last_grant;
  // One bit per FP register: a write to it has been issued but not yet written
  logic [DEPTH-1:0]  r_busy;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_err;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_xfer_addr;
  logic [DATA_W-1:0] w_xfer_data;
  logic              w_xfer_pending;
  logic              w_issue;
  logic [DEPTH-1:0]  w_set_mask;
  logic [DEPTH-1:0]  w_clr_mask;

  // Round-robin grant: a lone requester wins, on contention the one not granted last wins
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = !r_last_grant;
    end else begin
      w_grant0 = bus.req0_valid;
      w_grant1 = bus.req1_valid;
    end
  end

  // Select the winning write; grant implies valid, so a grant is a transfer
  always_comb begin
    w_xfer         = w_grant0 || w_grant1;
    w_xfer_addr    = w_grant1 ? bus.req1_addr : bus.req0_addr;
    w_xfer_data    = w_grant1 ? bus.req1_data : bus.req0_data;
    w_xfer_pending = r_busy[w_xfer_addr];
    w_issue        = bus.iss_valid && !r_busy[bus.iss_rd];
  end

  // Decode the scoreboard set (issue) and clear (transfer) one-hot masks
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_set_mask[i] = w_issue && (bus.iss_rd == ADDR_W'(i));
      w_clr_mask[i] = w_xfer && (w_xfer_addr == ADDR_W'(i));
    end
  end

  // Register the granted write onto the file port; address and data hold when idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_wr_en <= w_xfer;
      if (w_xfer) begin
        r_wr_addr    <= w_xfer_addr;
        r_wr_data    <= w_xfer_data;
        r_last_grant <= w_grant1;
      end
    end
  end

  // Scoreboard update: clear then set, so a same-index set takes priority
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end
  end

  // Flag a write to a register with no outstanding issue; sticky until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_xfer && !w_xfer_pending) begin
      r_err <= 1'b1;
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.iss_ready  = !r_busy[bus.iss_rd];

  // The write-port term covers the cycle where data is on the port but not yet readable
  assign bus.rs_busy = r_busy[bus.rs_addr] || (r_wr_en && (r_wr_addr == bus.rs_addr));
  assign bus.rt_busy = r_busy[bus.rt_addr] || (r_wr_en && (r_wr_addr == bus.rt_addr));

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// tb/tb_fpr_wb_arbiter.sv - randomized self-checking bench for fpr_wb_arbiter
module tb_fpr_wb_arbiter;

  logic clk;
  logic reset;

  fpr_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  fpr_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // Reference state: which registers await a write, who won last, the write port, error flag
  bit          m_busy [32];
  bit          m_last;
  bit          m_wr_en;
  logic [4:0]  m_wr_addr;
  logic [31:0] m_wr_data;
  bit          m_err;

  // Grants seen in the most recent cycle
  bit g0_seen;
  bit g1_seen;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last    = 1'b1;
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
    m_err     = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    bus.iss_valid  = 1'b0; bus.iss_rd    = '0;
    bus.rs_addr    = '0;   bus.rt_addr   = '0;
  endtask

  // Inputs are already driven (just after a falling edge). Compare everything against the
  // reference, advance the reference across the rising edge, return at the next falling edge.
  task automatic cycle();
    bit          e_g0, e_g1, iss_ok, xfer;
    logic [4:0]  xa;
    logic [31:0] xd;
    #1;
    if (bus.req0_valid && bus.req1_valid) begin
      e_g0 = (m_last == 1'b1);
      e_g1 = !e_g0;
    end else begin
      e_g0 = bus.req0_valid;
      e_g1 = bus.req1_valid;
    end
    check_val("req0_ready", bus.req0_ready, e_g0);
    check_val("req1_ready", bus.req1_ready, e_g1);
    check_val("iss_ready",  bus.iss_ready,  !m_busy[bus.iss_rd]);
    check_val("rs_busy", bus.rs_busy, m_busy[bus.rs_addr] || (m_wr_en && m_wr_addr == bus.rs_addr));
    check_val("rt_busy", bus.rt_busy, m_busy[bus.rt_addr] || (m_wr_en && m_wr_addr == bus.rt_addr));
    check_val("wr_en",   bus.wr_en,   m_wr_en);
    check_val("wr_addr", bus.wr_addr, m_wr_addr);
    check_val("wr_data", bus.wr_data, m_wr_data);
    check_val("err",     bus.err,     m_err);
    g0_seen = e_g0;
    g1_seen = e_g1;

    iss_ok = bus.iss_valid && !m_busy[bus.iss_rd];
    xfer   = e_g0 || e_g1;
    xa     = e_g0 ? bus.req0_addr : bus.req1_addr;
    xd     = e_g0 ? bus.req0_data : bus.req1_data;
    @(posedge clk);
    if (xfer) begin
      if (!m_busy[xa]) m_err = 1'b1;
      m_busy[xa] = 1'b0;
      m_wr_addr  = xa;
      m_wr_data  = xd;
      m_last     = e_g1;
    end
    m_wr_en = xfer;
    if (iss_ok) m_busy[bus.iss_rd] = 1'b1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [4:0] rd);
    idle_inputs();
    bus.iss_valid = 1'b1;
    bus.iss_rd    = rd;
    cycle();
  endtask

  int          grants [$];
  int          q0 [$];
  int          q1 [$];
  bit          hold0, hold1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  int          cand [$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset state visible on idle cycles
    repeat (2) cycle();

    // Reset mid-operation: pending 3 and 7, an error, a live write, then async reset
    issue(5'd3);
    issue(5'd7);
    idle_inputs(); bus.req1_valid = 1'b1; bus.req1_addr = 5'd20; bus.req1_data = 32'h1234;
    cycle();
    idle_inputs(); bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hAAAA;
    bus.rs_addr = 5'd3; bus.rt_addr = 5'd7;
    #1;
    check_val("pre_rst_wr_en", bus.wr_en, 1'b1);
    check_val("pre_rst_err",   bus.err,   1'b1);
    #1 reset = 1'b0;
    #1;
    check_val("rst_wr_en",   bus.wr_en,   1'b0);
    check_val("rst_err",     bus.err,     1'b0);
    check_val("rst_rs_busy", bus.rs_busy, 1'b0);
    check_val("rst_rt_busy", bus.rt_busy, 1'b0);
    check_val("rst_wr_addr", bus.wr_addr, 5'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(5'd3);
    issue(5'd7);
    idle_inputs();
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h11;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h22;
    cycle();
    check_val("first_grant_req0", g0_seen, 1'b1);
    idle_inputs(); bus.req1_valid = 1'b1; bus.req1_addr = 5'd7; bus.req1_data = 32'h22;
    cycle();
    idle_inputs(); cycle();

    // Single write with rs_busy tracking through the port cycle
    issue(5'd5);
    idle_inputs(); bus.rs_addr = 5'd5;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'h3F800000;
    cycle();
    check_val("single_ready", g0_seen, 1'b1);
    idle_inputs(); bus.rs_addr = 5'd5;
    #1;
    check_val("single_wr_addr", bus.wr_addr, 5'd5);
    check_val("single_wr_data", bus.wr_data, 32'h3F800000);
    check_val("single_rs_busy_port", bus.rs_busy, 1'b1);
    cycle();
    idle_inputs(); bus.rs_addr = 5'd5;
    #1;
    check_val("single_rs_busy_after", bus.rs_busy, 1'b0);
    cycle();

    // WAW stall on rd=9
    issue(5'd9);
    issue(5'd9);
    idle_inputs(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h99;
    cycle();
    idle_inputs(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    #1;
    check_val("waw_ready_after", bus.iss_ready, 1'b1);
    cycle();
    idle_inputs(); bus.req1_valid = 1'b1; bus.req1_addr = 5'd9; bus.req1_data = 32'h98;
    cycle();

    // Round-robin with both requesters held valid
    issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4);
    q0 = '{1, 3};
    q1 = '{2, 4};
    grants.delete();
    for (int c = 0; c < 8 && (q0.size() > 0 || q1.size() > 0); c++) begin
      idle_inputs();
      if (q0.size() > 0) begin
        bus.req0_valid = 1'b1; bus.req0_addr = 5'(q0[0]); bus.req0_data = 32'(q0[0] * 16);
      end
      if (q1.size() > 0) begin
        bus.req1_valid = 1'b1; bus.req1_addr = 5'(q1[0]); bus.req1_data = 32'(q1[0] * 16);
      end
      cycle();
      check_val("rr_one_ready", g0_seen && g1_seen, 1'b0);
      if (g0_seen) begin grants.push_back(0); void'(q0.pop_front()); end
      if (g1_seen) begin grants.push_back(1); void'(q1.pop_front()); end
    end
    check_val("rr_count", grants.size(), 4);
    for (int k = 0; k < grants.size() && k < 4; k++) check_val("rr_order", grants[k], k % 2);
    idle_inputs(); cycle();

    // Same-cycle set and clear on different indices
    issue(5'd11);
    idle_inputs(); bus.iss_valid = 1'b1; bus.iss_rd = 5'd10;
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd11; bus.req0_data = 32'hB;
    cycle();
    idle_inputs(); cycle();
    idle_inputs(); bus.rs_addr = 5'd10; bus.rt_addr = 5'd11;
    #1;
    check_val("sc_busy10", bus.rs_busy, 1'b1);
    check_val("sc_busy11", bus.rt_busy, 1'b0);
    cycle();
    idle_inputs(); bus.req0_valid = 1'b1; bus.req0_addr = 5'd10; bus.req0_data = 32'hA;
    cycle();

    // Protocol error: write to a register with nothing pending
    idle_inputs(); bus.req1_valid = 1'b1; bus.req1_addr = 5'd20; bus.req1_data = 32'hE0;
    cycle();
    idle_inputs();
    #1;
    check_val("perr_wr_addr", bus.wr_addr, 5'd20);
    check_val("perr_err", bus.err, 1'b1);
    repeat (3) cycle();

    // Clear everything, then randomized traffic against the reference
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    hold0 = 1'b0; hold1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (hold0 && $urandom_range(19) == 0) hold0 = 1'b0;
      if (hold1 && $urandom_range(19) == 0) hold1 = 1'b0;
      if (!hold0 && $urandom_range(1) == 1) begin
        cand.delete();
        foreach (m_busy[i]) if (m_busy[i] && !(hold1 && a1 == 5'(i))) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(199) != 0) a0 = 5'(cand[$urandom_range(cand.size() - 1)]);
        else a0 = 5'($urandom_range(31));
        d0 = $urandom; hold0 = 1'b1;
      end
      if (!hold1 && $urandom_range(1) == 1) begin
        cand.delete();
        foreach (m_busy[i]) if (m_busy[i] && !(hold0 && a0 == 5'(i))) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(199) != 0) a1 = 5'(cand[$urandom_range(cand.size() - 1)]);
        else a1 = 5'($urandom_range(31));
        d1 = $urandom; hold1 = 1'b1;
      end
      bus.req0_valid = hold0; bus.req0_addr = a0; bus.req0_data = d0;
      bus.req1_valid = hold1; bus.req1_addr = a1; bus.req1_data = d1;
      bus.iss_valid  = ($urandom_range(1) == 1);
      bus.iss_rd     = 5'($urandom_range(31));
      bus.rs_addr    = 5'($urandom_range(31));
      bus.rt_addr    = 5'($urandom_range(31));
      cycle();
      if (g0_seen) hold0 = 1'b0;
      if (g1_seen) hold1 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
